// File: rtl/alu_cond_stage.sv
// alu_cond_stage: 2-entry FIFO after the ALU that keeps the NZCV flags and gates register writes by condition (optional COND_EXEC_EN)
module alu_cond_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [3:0]  in_flags,
  input  logic [3:0]  in_cond,
  input  logic [1:0]  in_flagw,
  input  logic        in_regw,
  input  logic [3:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_rd,
  output logic        out_regw,
  output logic [3:0]  flags
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic push, pop, condex;
  logic [31:0] result1;
  logic [3:0] rd1;
  logic regw1;
  assign in_ready = state != TWO;
  assign out_valid = state != EMPTY;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
`ifdef COND_EXEC_EN
  logic n, z, c, v, base;
  assign {n, z, c, v} = flags;
  // Condition test against the flags as they stand before this entry updates them
  always_comb begin
    base = 1'b1;
    case (in_cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = n == v;
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    condex = (in_cond[3:1] == 3'd7) ? 1'b1 : base ^ in_cond[0];
  end
`else
  logic unused_cond;
  assign unused_cond = ^in_cond;
  assign condex = 1'b1;
`endif
  // FIFO occupancy register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= EMPTY;
    else state <= state_nx;
  // Occupancy next-state from push/pop
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: state_nx = push ? ONE : EMPTY;
      ONE: state_nx = (push & ~pop) ? TWO : (pop & ~push) ? EMPTY : ONE;
      TWO: state_nx = pop ? ONE : TWO;
      default: state_nx = EMPTY;
    endcase
  end
  // Head slot drives the outputs directly; second slot shifts in on pop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_result <= '0;
      out_rd <= '0;
      out_regw <= 1'b0;
      result1 <= '0;
      rd1 <= '0;
      regw1 <= 1'b0;
    end else begin
      if (push && (state == EMPTY || (state == ONE && pop))) begin
        out_result <= in_result;
        out_rd <= in_rd;
        out_regw <= in_regw & condex;
      end else if (pop && state == TWO) begin
        out_result <= result1;
        out_rd <= rd1;
        out_regw <= regw1;
      end
      if (push && state == ONE && !pop) begin
        result1 <= in_result;
        rd1 <= in_rd;
        regw1 <= in_regw & condex;
      end
    end
  // Architectural flags change only when a passing entry is accepted
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) flags <= 4'b0000;
    else if (push && condex) begin
      if (in_flagw[1]) flags[3:2] <= in_flags[3:2];
      if (in_flagw[0]) flags[1:0] <= in_flags[1:0];
    end
endmodule

// File: doc/alu_cond_stage.md
ALU_COND_STAGE -- requirements
Module: alu_cond_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_valid  in  1  ALU-side transaction present; in_ready  out  1  stage can accept.
REQ-004 SHALL have ports: in_result  in  32  ALU Result; in_flags  in  4  ALU flags {N,Z,C,V}.
REQ-005 SHALL have ports: in_cond  in  4  instruction condition field; in_flagw  in  2  flag-write enables ([1]=N,Z; [0]=C,V); in_regw  in  1  register-write request; in_rd  in  4  destination register.
REQ-006 SHALL have ports: out_valid  out  1; out_ready  in  1; out_result  out  32; out_rd  out  4; out_regw  out  1  condition-qualified write enable; flags  out  4  architectural NZCV register.
REQ-007 SHALL have no parameters; all widths fixed as listed.

Function
REQ-008 Transfer on input SHALL occur when in_valid and in_ready are both 1 at a rising clk edge; transfer on output when out_valid and out_ready are both 1.
REQ-009 Buffer SHALL be a 2-entry in-order FIFO with states EMPTY, ONE, TWO; out_valid = (state != EMPTY); in_ready = (state != TWO).
REQ-010 Transitions: EMPTY+push->ONE; ONE+push only->TWO; ONE+pop only->EMPTY; ONE+push+pop->ONE; TWO+pop->ONE; no event->hold.
REQ-011 in_ready SHALL depend only on state (no combinational path from out_ready).
REQ-012 Latency: entry accepted at edge N SHALL be visible on outputs after edge N when buffer was EMPTY; minimum latency 1 cycle, no combinational input-to-output path.
REQ-013 Output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-014 Condition pass (condex) SHALL be evaluated at acceptance against the current flags register (pre-update value): 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as 1.
REQ-015 On acceptance with condex=1: flags[3:2] <= in_flags[3:2] if in_flagw[1]; flags[1:0] <= in_flags[1:0] if in_flagw[0]; otherwise flags hold.
REQ-016 On acceptance with condex=0: flags SHALL hold; entry still enters FIFO with stored regw=0 (squashed, order preserved).
REQ-017 Stored regw SHALL equal in_regw & condex; out_result and out_rd SHALL be stored unmodified.
REQ-018 Back-to-back accepted entries SHALL see flag updates of all earlier accepted entries (update visible on the next edge).
REQ-019 Flags SHALL update only on acceptance, independent of output-side stalls.

Reset
REQ-020 reset_n=0 SHALL immediately force state=EMPTY, out_valid=0, in_ready=1, flags=4'b0000, out_result=0, out_rd=0, out_regw=0.
REQ-021 Reset asserted mid-operation SHALL discard all buffered entries; no partial flag update SHALL survive.
REQ-022 First acceptance SHALL be possible at the first rising edge after reset_n deasserts.

Configuration
REQ-023 Macro COND_EXEC_EN defined: condition evaluation per REQ-014..REQ-017.
REQ-024 Macro COND_EXEC_EN undefined: condex SHALL be constant 1 for every in_cond (all instructions execute; flags and regw follow in_flagw/in_regw unconditionally); FIFO and handshake unchanged.

Verification
REQ-025 Reset, then push result=0x0000_0005, rd=3, regw=1, cond=1110, out_ready=1 -> out_valid next cycle, out_result=0x5, out_rd=3, out_regw=1.
REQ-026 Push flags=0100, flagw=11, cond=1110; then push cond=0000 (EQ), regw=1 -> second entry out_regw=1; repeat with cond=0001 (NE) -> out_regw=0 and flags remain 0100.
REQ-027 Hold out_ready=0, push 3 entries -> in_ready=0 after second accept, third held; release out_ready -> outputs in order, no loss or duplicate.
REQ-028 State ONE with simultaneous push and pop each cycle for 8 cycles -> state stays ONE, throughput 1/cycle.
REQ-029 Assert reset_n=0 with TWO entries and flags=1111 -> out_valid=0, flags=0000 immediately, in_ready=1.
REQ-030 Build without COND_EXEC_EN, flags=0000, push cond=0000 regw=1 flagw=10 in_flags=1000 -> out_regw=1, flags=1000.
